// File: rtl/align_shift_right.sv
// Aligns two IEEE-754 single operands for addition: the smaller mantissa is shifted right to the larger exponent.
// Latency: 1 cycle when the exponent difference is 0 or >= 27, otherwise 1 + ceil(d/4) cycles (4-bit shift per cycle).
// Backpressure: one operation in flight; in_ready only in IDLE, the result is held in DONE until out_ready.
module align_shift_right (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  EXP,
  output logic [23:0] MA,
  output logic [26:0] MB,
  output logic        SA,
  output logic        SB,
  output logic        SWAP
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [26:0] w;
  logic [7:0]  rem;

  logic [7:0]  exp_a, exp_b, exp_large, exp_small, diff;
  logic [23:0] mant_a, mant_b, mant_large, mant_small;
  logic        swap_c, sign_large, sign_small;

  logic [2:0]  k;
  logic [26:0] lost_mask;
  logic [26:0] shifted;
  logic        lost;
  logic [26:0] w_next;

  // Unpack both operands and pick the larger one by exponent, then mantissa.
  always_comb begin
    exp_a      = A[30:23];
    exp_b      = B[30:23];
    mant_a     = {(exp_a != 8'd0), A[22:0]};
    mant_b     = {(exp_b != 8'd0), B[22:0]};
    swap_c     = (exp_b > exp_a) || ((exp_b == exp_a) && (mant_b > mant_a));
    exp_large  = swap_c ? exp_b  : exp_a;
    exp_small  = swap_c ? exp_a  : exp_b;
    mant_large = swap_c ? mant_b : mant_a;
    mant_small = swap_c ? mant_a : mant_b;
    sign_large = swap_c ? B[31]  : A[31];
    sign_small = swap_c ? A[31]  : B[31];
    diff       = exp_large - exp_small;
  end

  // One shift step of up to 4 bits; every bit leaving the register is folded into bit 0 as sticky.
  always_comb begin
    k         = (rem >= 8'd4) ? 3'd4 : rem[2:0];
    lost_mask = (27'd1 << k) - 27'd1;
    lost      = |(w & lost_mask);
    shifted   = w >> k;
    w_next    = {shifted[26:1], shifted[0] | lost | w[0]};
  end

  assign MB = w;

  // Handshake FSM; all datapath registers load at acceptance and are held until the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      EXP       <= 8'd0;
      MA        <= 24'd0;
      SA        <= 1'b0;
      SB        <= 1'b0;
      SWAP      <= 1'b0;
      w         <= 27'd0;
      rem       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            EXP  <= exp_large;
            MA   <= mant_large;
            SA   <= sign_large;
            SB   <= sign_small;
            SWAP <= swap_c;
            in_ready <= 1'b0;
            if (diff == 8'd0) begin
              w         <= {mant_small, 3'b000};
              rem       <= 8'd0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (diff >= 8'd27) begin
              // Everything shifts out: only the sticky survives.
              w         <= {26'd0, (mant_small != 24'd0)};
              rem       <= 8'd0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              w     <= {mant_small, 3'b000};
              rem   <= diff;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w   <= w_next;
          rem <= rem - {5'd0, k};
          if (rem == {5'd0, k}) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_align_shift_right.sv
// Bench for align_shift_right: directed vectors, backpressure, reset abort, then randomized operand pairs.
// Expected results come from an arithmetic model of the alignment (full-width shift with sticky OR).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_align_shift_right;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  EXP;
  logic [23:0] MA;
  logic [26:0] MB;
  logic        SA, SB, SWAP;

  int n_cmp = 0;
  int n_err = 0;

  align_shift_right dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .EXP(EXP), .MA(MA), .MB(MB), .SA(SA), .SB(SB), .SWAP(SWAP)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: choose the larger operand, then shift {mant_small,000} right by d at full width.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [7:0] e, output logic [23:0] ma,
                                output logic [26:0] mb, output logic sa,
                                output logic sb, output logic sw, output int lat);
    int unsigned ea, eb, fa, fb, el, es, fs, d;
    longint unsigned wv, res;
    ea = a[30:23];
    eb = b[30:23];
    fa = a[22:0] + ((ea != 0) ? 32'h800000 : 32'h0);
    fb = b[22:0] + ((eb != 0) ? 32'h800000 : 32'h0);
    sw = (eb > ea) || (eb == ea && fb > fa);
    el = sw ? eb : ea;
    es = sw ? ea : eb;
    fs = sw ? fa : fb;
    ma = sw ? fb[23:0] : fa[23:0];
    sa = sw ? b[31] : a[31];
    sb = sw ? a[31] : b[31];
    e  = el[7:0];
    d  = el - es;
    wv = longint'(fs) * 8;
    if (d >= 27) res = (fs != 0) ? 1 : 0;
    else res = (wv >> d) | (((wv & ((64'd1 << d) - 1)) != 0) ? 1 : 0);
    mb  = res[26:0];
    lat = (d == 0 || d >= 27) ? 1 : 1 + (d + 3) / 4;
  endfunction

  // Full transaction: accept, scramble inputs while busy, check latency and result, apply backpressure, hand off.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [7:0] e; logic [23:0] ma; logic [26:0] mb; logic sa, sb, sw; int lat, c;
    model(a, b, e, ma, mb, sa, sb, sw, lat);
    chk({tag, "_in_ready"}, in_ready, 1);
    A = a; B = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 1;
    while (out_valid !== 1'b1 && c < 40) begin
      A = $urandom; B = $urandom; in_valid = 1'($urandom);
      tick();
      c++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_exp"},  EXP, e);
    chk({tag, "_ma"},   MA, ma);
    chk({tag, "_mb"},   MB, mb);
    chk({tag, "_sgn"},  {SA, SB, SWAP}, {sa, sb, sw});
    for (int i = 0; i < hold; i++) begin
      A = $urandom; B = $urandom; in_valid = 1'($urandom);
      tick();
      chk({tag, "_hold"}, {out_valid, in_ready, EXP, MA, MB, SA, SB, SWAP},
          {1'b1, 1'b0, e, ma, mb, sa, sb, sw});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int ea, eb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_hs", {out_valid, in_ready}, 2'b01);
    chk("reset_data", {EXP, MA, MB, SA, SB, SWAP}, 64'd0);

    run_op("d1",        32'h40400000, 32'h3F800000, 0);
    run_op("d1_swap",   32'h3F800000, 32'h40400000, 0);
    run_op("d30",       32'h4E800000, 32'h3F800000, 0);
    run_op("d26",       32'h4C800000, 32'h3F800001, 0);
    run_op("backpress", 32'hC1200000, 32'h3E4CCCCD, 5);
    run_op("btb",       32'h3F800000, 32'hBF800000, 0);
    run_op("equal",     32'h12345678, 32'h12345678, 1);
    run_op("denorm",    32'h00400001, 32'h00800000, 0);
    run_op("inf_nan",   32'h7F800000, 32'h7FC00001, 0);
    run_op("d27",       32'h4D000000, 32'h3F800000, 0);
    run_op("zero",      32'h40000000, 32'h00000000, 0);

    // Reset asserted on the third SHIFT cycle of the d=26 case aborts the result.
    A = 32'h4C800000; B = 32'h3F800001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_hs", {out_valid, in_ready}, 2'b01);
    chk("abort_data", {EXP, MA, MB, SA, SB, SWAP}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_quiet", out_valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      ea = $urandom_range(0, 255);
      eb = ea + $urandom_range(0, 64) - 32;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      ra = $urandom; ra[30:23] = ea[7:0];
      rb = $urandom; rb[30:23] = eb[7:0];
      if ($urandom_range(0, 7) == 0) rb[22:0] = ra[22:0];
      run_op("rand", ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
